mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one single-outstanding memory port between a fetch requester (if_*)
// and a data requester (dm_*). Grants are combinational in IDLE; the accepted
// request is captured into the registered mem_* outputs and held until the
// memory acknowledges or the timeout aborts the transaction.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   if_req, if_addr                    fetch request (held until if_gnt)
//   if_gnt, if_rvalid, if_rdata        fetch accept pulse, completion pulse, data
//   dm_req, dm_we, dm_be, dm_addr,
//   dm_wdata                           data request (held until dm_gnt)
//   dm_gnt, dm_rvalid, dm_rdata        data accept pulse, completion pulse, load data
//   mem_req, mem_we, mem_be, mem_addr,
//   mem_wdata                          registered memory-side request
//   mem_ack, mem_rdata                 memory completion and read data
//   err                                one-cycle pulse on timeout abort
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tcnt;
  logic          starve_sat;
  logic          timeout_hit;
  logic          busy;
  logic          finish;
  logic [31:0]   finish_data;

  assign starve_sat  = (starve_cnt == SW'(STARVE_LIMIT));
  assign busy        = (state != IDLE);
  assign finish      = busy && (mem_ack || timeout_hit);
  // An abort completes the transaction with zero data.
  assign finish_data = mem_ack ? mem_rdata : 32'h0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grants. Grants are gated with rst_n so they read 0 while
  // reset is held, even though the decode itself sits in IDLE.
  // The data side wins ties until it has starved fetch for STARVE_LIMIT grants.
  // Ack takes priority over a timeout reached in the same cycle.
  always_comb begin
    state_next  = state;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && if_req && (!dm_req || starve_sat)) begin
          if_gnt     = 1'b1;
          state_next = BUSY_IF;
        end else if (rst_n && dm_req) begin
          dm_gnt     = 1'b1;
          state_next = BUSY_DM;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack) begin
          state_next = IDLE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, memory port, completion pulses and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'h0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= 32'h0;
      err        <= 1'b0;
      starve_cnt <= '0;
      tcnt       <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      err       <= 1'b0;

      if (if_gnt) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_be     <= 4'hF;
        mem_addr   <= if_addr;
        mem_wdata  <= 32'h0;
        tcnt       <= '0;
        starve_cnt <= '0;
      end else if (dm_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_be    <= dm_be;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        tcnt      <= '0;
        if (if_req && !starve_sat) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end

      if (finish) begin
        mem_req <= 1'b0;
        err     <= timeout_hit;
        if (state == BUSY_IF) begin
          if_rvalid <= 1'b1;
          if_rdata  <= finish_data;
        end else begin
          dm_rvalid <= 1'b1;
          // Stores report completion with zero data.
          dm_rdata  <= mem_we ? 32'h0 : finish_data;
        end
      end else if (busy) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter
// Directed testbench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
// A small memory responder acknowledges a configurable number of cycles after
// mem_req rises. A transaction-level model checks every output on each falling
// edge; directed scenarios add hand-computed literal expectations.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  int          ack_delay = 255;
  logic        force_ack = 1'b0;
  logic [31:0] rd_value  = 32'h0;
  int          busy_cycles = 0;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ifa,
                               input logic dmr, input logic we,
                               input logic [3:0] be, input logic [31:0] da,
                               input logic [31:0] wd);
    if_req   = ifr;
    if_addr  = ifa;
    dm_req   = dmr;
    dm_we    = we;
    dm_be    = be;
    dm_addr  = da;
    dm_wdata = wd;
  endtask

  // Advance cycle by cycle until the chosen rvalid is seen (bounded).
  task automatic waitRvalid(input bit want_dm, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      @(negedge clk);
      seen = want_dm ? dm_rvalid : if_rvalid;
    end
    checkOutput(want_dm ? "dm_rvalid seen" : "if_rvalid seen",
                {31'h0, want_dm ? dm_rvalid : if_rvalid}, 32'h1);
  endtask

  // Memory responder: acks ack_delay cycles after mem_req rises; force_ack
  // injects a spurious ack while the port is idle.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req) begin
        mem_ack = (busy_cycles == ack_delay);
        busy_cycles++;
      end else begin
        busy_cycles = 0;
        mem_ack     = force_ack;
      end
      mem_rdata = rd_value;
    end
  end

  // Transaction-level model: owner 0 = none, 1 = fetch, 2 = data.
  int          m_owner  = 0;
  int          m_waited = 0;
  int          m_streak = 0;
  logic        m_req = 1'b0, m_we = 1'b0;
  logic [3:0]  m_be = 4'h0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
  logic        e_if_rvalid = 1'b0, e_dm_rvalid = 1'b0, e_err = 1'b0;
  logic [31:0] e_if_rdata = 32'h0, e_dm_rdata = 32'h0;
  logic        e_if_gnt, e_dm_gnt, m_done;
  logic [31:0] m_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = 0; m_waited = 0; m_streak = 0;
      m_req = 1'b0; m_we = 1'b0; m_be = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
      e_if_rvalid = 1'b0; e_dm_rvalid = 1'b0; e_err = 1'b0;
      e_if_rdata = 32'h0; e_dm_rdata = 32'h0;
    end
    e_if_gnt = rst_n && (m_owner == 0) && if_req &&
               (!dm_req || m_streak >= STARVE_LIMIT);
    e_dm_gnt = rst_n && (m_owner == 0) && dm_req && !e_if_gnt;

    checkOutput("model if_gnt",    {31'h0, if_gnt},    {31'h0, e_if_gnt});
    checkOutput("model dm_gnt",    {31'h0, dm_gnt},    {31'h0, e_dm_gnt});
    checkOutput("model if_rvalid", {31'h0, if_rvalid}, {31'h0, e_if_rvalid});
    checkOutput("model dm_rvalid", {31'h0, dm_rvalid}, {31'h0, e_dm_rvalid});
    checkOutput("model err",       {31'h0, err},       {31'h0, e_err});
    checkOutput("model if_rdata",  if_rdata, e_if_rdata);
    checkOutput("model dm_rdata",  dm_rdata, e_dm_rdata);
    checkOutput("model mem_req",   {31'h0, mem_req},   {31'h0, m_req});
    if (!rst_n || m_req) begin
      checkOutput("model mem_addr", mem_addr, m_addr);
      checkOutput("model mem_we",   {31'h0, mem_we}, {31'h0, m_we});
      checkOutput("model mem_be",   {28'h0, mem_be}, {28'h0, m_be});
    end
    if (!rst_n || (m_req && m_we)) begin
      checkOutput("model mem_wdata", mem_wdata, m_wdata);
    end

    if (rst_n) begin
      e_if_rvalid = 1'b0;
      e_dm_rvalid = 1'b0;
      e_err       = 1'b0;
      if (m_owner != 0) begin
        m_done = 1'b0;
        m_data = 32'h0;
        if (mem_ack) begin
          m_done = 1'b1;
          m_data = mem_rdata;
        end else if (m_waited + 1 >= TIMEOUT) begin
          m_done = 1'b1;
          e_err  = 1'b1;
        end else begin
          m_waited++;
        end
        if (m_done) begin
          if (m_owner == 1) begin
            e_if_rvalid = 1'b1;
            e_if_rdata  = m_data;
          end else begin
            e_dm_rvalid = 1'b1;
            e_dm_rdata  = m_we ? 32'h0 : m_data;
          end
          m_owner = 0;
          m_req   = 1'b0;
        end
      end
      if (e_if_gnt) begin
        m_owner = 1; m_waited = 0; m_streak = 0;
        m_req = 1'b1; m_we = 1'b0; m_be = 4'hF; m_addr = if_addr;
      end else if (e_dm_gnt) begin
        m_owner = 2; m_waited = 0;
        if (if_req && m_streak < STARVE_LIMIT) m_streak++;
        m_req = 1'b1; m_we = dm_we; m_be = dm_be; m_addr = dm_addr; m_wdata = dm_wdata;
      end
    end
  end

  int seq [10];
  int exp_seq [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  int n, k, cyc, dm_pulses, if_pulses;
  bit seen;

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    ack_delay = 2;
    rd_value  = 32'h0000_0013;

    // Reset held with a pending fetch: nothing granted, port quiet.
    tick(); tick();
    @(negedge clk);
    checkOutput("reset if_gnt", {31'h0, if_gnt}, 32'h0);
    checkOutput("reset mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("reset err", {31'h0, err}, 32'h0);

    // Fetch: granted the first cycle after release, rvalid 4 cycles later.
    tick(); rst_n = 1'b1;
    @(negedge clk);
    checkOutput("fetch gnt c0", {31'h0, if_gnt}, 32'h1);
    tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("fetch mem_addr c1", mem_addr, 32'h100);
    checkOutput("fetch mem_be c1", {28'h0, mem_be}, 32'hF);
    waitRvalid(1'b0, cyc);
    checkOutput("fetch rvalid cycle", cyc, 3);
    checkOutput("fetch rdata", if_rdata, 32'h0000_0013);

    // Data load.
    tick(); ack_delay = 1; rd_value = 32'h55AA_1234;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    @(negedge clk);
    checkOutput("load gnt", {31'h0, dm_gnt}, 32'h1);
    tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    waitRvalid(1'b1, cyc);
    checkOutput("load rvalid cycle", cyc, 2);
    checkOutput("load rdata", dm_rdata, 32'h55AA_1234);

    // Data store: fields on the port, zero completion data, fetch data held.
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("store gnt", {31'h0, dm_gnt}, 32'h1);
    tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("store mem_we", {31'h0, mem_we}, 32'h1);
    checkOutput("store mem_be", {28'h0, mem_be}, 32'h3);
    checkOutput("store mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("store mem_addr", mem_addr, 32'h2000);
    waitRvalid(1'b1, cyc);
    checkOutput("store rvalid cycle", cyc, 2);
    checkOutput("store dm_rdata", dm_rdata, 32'h0);
    checkOutput("if_rdata held", if_rdata, 32'h0000_0013);

    // Both requesters held: four data grants, then one fetch, repeating.
    tick(); ack_delay = 0; rd_value = 32'hCAFE_0001;
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk);
      if (if_gnt) begin seq[n] = 1; n++; end
      else if (dm_gnt) begin seq[n] = 2; n++; end
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("starve grant count", n, 10);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("starve grant %0d (1=if 2=dm)", i), seq[i], exp_seq[i]);
    end
    tick(); tick(); tick();

    // Timeout: no ack, err 8 cycles after mem_req rises; waiting data request
    // is granted in the same cycle.
    tick(); ack_delay = 255;
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("timeout fetch gnt", {31'h0, if_gnt}, 32'h1);
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      tick(); k++;
      if (k == 1) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      if (k == 3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
      @(negedge clk);
      seen = err;
    end
    checkOutput("timeout err cycle", k, 9);
    checkOutput("timeout if_rvalid", {31'h0, if_rvalid}, 32'h1);
    checkOutput("timeout if_rdata", if_rdata, 32'h0);
    checkOutput("timeout mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("timeout next dm_gnt", {31'h0, dm_gnt}, 32'h1);
    tick(); ack_delay = 0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    waitRvalid(1'b1, cyc);
    checkOutput("after timeout load data", dm_rdata, 32'hCAFE_0001);

    // Ack arriving in the very cycle the timeout is reached wins.
    tick(); ack_delay = 7; rd_value = 32'h77;
    applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("late ack gnt", {31'h0, if_gnt}, 32'h1);
    tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    waitRvalid(1'b0, cyc);
    checkOutput("late ack rvalid cycle", cyc, 8);
    checkOutput("late ack no err", {31'h0, err}, 32'h0);
    checkOutput("late ack rdata", if_rdata, 32'h77);

    // Reset during a data transaction.
    tick(); ack_delay = 255;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h3000, 32'h0);
    @(negedge clk);
    checkOutput("pre-reset dm_gnt", {31'h0, dm_gnt}, 32'h1);
    tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checkOutput("async reset mem_req", {31'h0, mem_req}, 32'h0);
    checkOutput("async reset mem_addr", mem_addr, 32'h0);
    checkOutput("async reset if_rdata", if_rdata, 32'h0);
    tick(); tick();
    rst_n = 1'b1; ack_delay = 1; rd_value = 32'h5555;
    applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("post-reset if_gnt", {31'h0, if_gnt}, 32'h1);
    tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    dm_pulses = 0; if_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dm_pulses += int'(dm_rvalid);
      if_pulses += int'(if_rvalid);
      tick();
    end
    checkOutput("post-reset dm_rvalid pulses", dm_pulses, 0);
    checkOutput("post-reset if_rvalid pulses", if_pulses, 1);

    // Spurious ack while idle is ignored.
    tick(); force_ack = 1'b1; rd_value = 32'h9999;
    @(negedge clk);
    tick(); force_ack = 1'b0;
    @(negedge clk);
    checkOutput("spurious if_rvalid", {31'h0, if_rvalid}, 32'h0);
    checkOutput("spurious dm_rvalid", {31'h0, dm_rvalid}, 32'h0);
    checkOutput("spurious mem_req", {31'h0, mem_req}, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("after spurious if_gnt", {31'h0, if_gnt}, 32'h1);
    tick(); applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    waitRvalid(1'b0, cyc);
    checkOutput("after spurious rdata", if_rdata, 32'h9999);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
